// File: rtl/bmp_stream_loader.sv
// Streams a BMP image from ROM to RAM one byte per cycle,
// applying a per-pixel transform after the header.
module bmp_stream_loader #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int TOTAL_SIZE = 786486,
  parameter int RAM_BASE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            mode,
  input  logic [BYTE_WIDTH-1:0] ROM_out,
  output logic                  ROM_ren,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_wen,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PW = 4 * BYTE_WIDTH;
  localparam int CW = PW + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(RAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] OFF_LO = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] OFF_HI = ADDR_WIDTH'(13);
  localparam logic [CW-1:0] HDR = CW'(14);
  localparam logic [CW-1:0] SIZE = CW'(TOTAL_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  armed_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q;
  logic                  wr_valid_q;
  logic [PW-1:0]         pix_off_q;
  logic                  err_q;

  logic                  start;
  logic                  cap_en;
  logic [1:0]            cap_sel;
  logic [PW-1:0]         off_full;
  logic                  off_bad;
  logic                  is_pix;
  logic [BYTE_WIDTH-1:0] wdata;

  assign start = (state_q == IDLE) && in_valid && armed_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rd_addr_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Header offset bytes 10..13 arrive on the write side, little-endian.
  assign cap_en  = wr_valid_q && (wr_idx_q >= OFF_LO) &&
                   (wr_idx_q <= OFF_HI);
  assign cap_sel = 2'(wr_idx_q - OFF_LO);
  assign off_full = {ROM_out, pix_off_q[3*BYTE_WIDTH-1:0]};
  assign off_bad  = (CW'(off_full) < HDR) || (CW'(off_full) >= SIZE);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b1;
      mode_q     <= 2'b00;
      rd_addr_q  <= '0;
      wr_idx_q   <= '0;
      wr_valid_q <= 1'b0;
      pix_off_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_valid_q <= (state_q == READ);
      wr_idx_q   <= rd_addr_q;
      if (state_q == IDLE && !in_valid) armed_q <= 1'b1;
      else if (state_q == DRAIN)        armed_q <= 1'b0;
      if (start) begin
        mode_q    <= mode;
        err_q     <= 1'b0;
        rd_addr_q <= '0;
      end else if (state_q == READ) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (cap_en && cap_sel == 2'(k))
          pix_off_q[k*BYTE_WIDTH +: BYTE_WIDTH] <= ROM_out;
      end
      if (wr_valid_q && wr_idx_q == OFF_HI) err_q <= off_bad;
    end
  end

  // err_q is settled before byte 14, so a bad offset disables the transform.
  assign is_pix = (CW'(wr_idx_q) >= HDR) && !err_q &&
                  (CW'(wr_idx_q) >= CW'(pix_off_q));

  always_comb begin
    wdata = ROM_out;
    if (is_pix) begin
      unique case (1'b1)
        (mode_q == 2'b01): wdata = ~ROM_out;
        (mode_q == 2'b10): wdata = '0;
        default:           wdata = ROM_out;
      endcase
    end
  end

  assign ROM_ren  = (state_q == READ);
  assign ROM_addr = ROM_ren ? rd_addr_q : '0;
  assign RAM_wen  = wr_valid_q;
  assign RAM_addr = wr_valid_q ? wr_idx_q + BASE : '0;
  assign RAM_in   = wr_valid_q ? wdata : '0;
  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule
